freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter CLK_REF, default 50_000_000, reference clock frequency in Hz.
REQ-002 Parameter GATE_HZ, default 1_000, gate rate; gate window = GATE_CYC = CLK_REF/GATE_HZ clk_en-qualified cycles.
REQ-003 Parameter W_EDGE, default 20, width of the edge counter.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset_l  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 clk_en  input  1  cycle qualifier; when low, all state, counters and outputs hold.
REQ-007 run  input  1  level; high = measure continuously, low = stop.
REQ-008 sig_in  input  1  asynchronous signal under measurement.
REQ-009 relax_freq  output  32  last measured frequency in Hz, feeds the downstream range decider.
REQ-010 work  output  1  level; high while relax_freq holds a result from an uninterrupted window.
REQ-011 ovf  output  1  last window saturated the edge counter or the product.
REQ-012 no_sig  output  1  last window counted zero edges.

Function
REQ-013 sig_in passes a 2-flop synchronizer, then a 1-flop rising-edge detector (edge = sync & ~prev); edge-detect latency is 3 cycles.
REQ-014 FSM states: IDLE, GATE, LATCH; transitions occur only on clk_en-high cycles.
REQ-015 IDLE: gate_cnt=0, edge_cnt=0; run=1 -> GATE.
REQ-016 GATE: gate_cnt increments each cycle; an edge increments edge_cnt; at gate_cnt==GATE_CYC-1 -> LATCH.
REQ-017 An edge on the final GATE cycle counts in the current window.
REQ-018 edge_cnt saturates at 2^W_EDGE-1 and sets an internal sat flag; it never wraps.
REQ-019 LATCH (one cycle): relax_freq <= edge_cnt*GATE_HZ, saturated to 32'hFFFF_FFFF; ovf <= sat | product saturation; no_sig <= (edge_cnt==0); work <= 1.
REQ-020 From LATCH: run=1 -> GATE with counters cleared (back-to-back windows, one dead cycle; an edge in LATCH is dropped); run=0 -> IDLE.
REQ-021 run=0 in GATE aborts to IDLE next cycle: counters cleared, work <= 0, relax_freq/ovf/no_sig hold.
REQ-022 Update latency: outputs change on the clock edge ending the LATCH cycle; work stays high across subsequent windows until an abort or reset.
REQ-023 clk_en low in any state freezes FSM, synchronizer, edge detector and counters; no edge is lost or double-counted across a freeze of the sampled signal.
REQ-024 Multiplication uses a constant GATE_HZ and a 32+W_EDGE-bit intermediate before saturation.

Reset
REQ-025 reset_l=1: state IDLE, synchronizer/prev flops 0, gate_cnt 0, edge_cnt 0, sat 0.
REQ-026 Reset values: relax_freq=0, work=0, ovf=0, no_sig=0.
REQ-027 Reset has priority over clk_en and run, and mid-window reset discards the partial count.

Structure
REQ-028 Package freq_meter_pkg holds the FSM state enum (IDLE/GATE/LATCH) and default constants CLK_REF_DEF, GATE_HZ_DEF.
REQ-029 One sub-module edge_sync (2-flop synchronizer + rising-edge detector, clk_en-qualified); counters, FSM and scaling stay in freq_meter.

Verification
REQ-030 500 kHz square wave (100-cycle period), run=1, defaults -> after the first LATCH: relax_freq=500_000, work=1, ovf=0, no_sig=0.
REQ-031 sig_in held 0, run=1 -> relax_freq=0, no_sig=1, work=1 after the first window (50_000 cycles + latency).
REQ-032 W_EDGE=4, 500 kHz input -> edge_cnt saturates at 15, relax_freq=15_000, ovf=1.
REQ-033 run dropped at gate_cnt=25_000 -> IDLE next cycle, work=0, relax_freq keeps its previous value; run re-raised -> fresh full window.
REQ-034 clk_en toggled 50% during a 500 kHz input whose edges are seen only on enabled cycles -> window spans 100_000 clk cycles, result equals the count of enabled-cycle edges, times 1000.
REQ-035 reset_l pulsed high mid-GATE -> all outputs 0 next cycle, FSM IDLE, then GATE on the next cycle with run=1.

Source files
------------

// File: rtl/freq_meter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : freq_meter_pkg                                                 |
// | Purpose   : Shared types and default constants for the gated frequency     |
// |             meter: FSM state encoding, default reference clock and gate    |
// |             rate, result width and a gate-length helper.                   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package freq_meter_pkg;

   // Measurement controller states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GATE  = 2'd1,
      LATCH = 2'd2
   } state_t;

   localparam int unsigned CLK_REF_DEF = 50_000_000;
   localparam int unsigned GATE_HZ_DEF = 1_000;
   localparam int unsigned FREQ_W      = 32;

   // Number of clk_en-qualified cycles in one gate window.
   function automatic int unsigned gate_cycles(input int unsigned clk_ref,
                                               input int unsigned gate_hz);
      return clk_ref / gate_hz;
   endfunction

endpackage : freq_meter_pkg
`default_nettype wire

// File: rtl/freq_meter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : freq_meter_if                                                  |
// | Purpose   : Bundles the control inputs and measurement results of the      |
// |             frequency meter.                                               |
// | Signals   : clk_en      cycle qualifier                                    |
// |             run         level, measure continuously while high             |
// |             sig_in      asynchronous signal under measurement              |
// |             relax_freq  last measured frequency in Hz (FREQ_W bits)        |
// |             work        result comes from an uninterrupted window          |
// |             ovf         last window saturated counter or product           |
// |             no_sig      last window counted zero edges                     |
// | Modports  : master - stimulus / consumer side                              |
// |             slave  - meter side                                            |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface freq_meter_if;
   import freq_meter_pkg::*;

   logic              clk_en;
   logic              run;
   logic              sig_in;
   logic [FREQ_W-1:0] relax_freq;
   logic              work;
   logic              ovf;
   logic              no_sig;

   modport master (
      output clk_en,
      output run,
      output sig_in,
      input  relax_freq,
      input  work,
      input  ovf,
      input  no_sig
   );

   modport slave (
      input  clk_en,
      input  run,
      input  sig_in,
      output relax_freq,
      output work,
      output ovf,
      output no_sig
   );

endinterface : freq_meter_if
`default_nettype wire

// File: rtl/freq_meter_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : edge_sync                                                      |
// | Purpose   : Two-flop synchronizer followed by a one-flop rising-edge       |
// |             detector. Every flop advances only on clk_en-high cycles, so   |
// |             a frozen stretch neither loses nor repeats an edge.            |
// | Ports     : clk       clock                                                |
// |             reset_l   synchronous active-high reset                        |
// |             clk_en    cycle qualifier                                      |
// |             sig_in    asynchronous input                                   |
// |             edge_det  one-cycle rising-edge indication (combinational)     |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module edge_sync
   import freq_meter_pkg::*;
(
   input  wire logic clk,
   input  wire logic reset_l,
   input  wire logic clk_en,
   input  wire logic sig_in,
   output logic      edge_det
);

   logic sync_1;
   logic sync_2;
   logic prev;

   always_ff @(posedge clk) begin
      if (reset_l) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         prev   <= 1'b0;
      end else if (clk_en) begin
         sync_1 <= sig_in;
         sync_2 <= sync_1;
         prev   <= sync_2;
      end
   end

   // Held steady while clk_en is low, but the consumer also only acts on
   // enabled cycles, so a frozen edge is counted exactly once.
   assign edge_det = sync_2 & ~prev;

endmodule : edge_sync
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : freq_meter                                                     |
// | Purpose   : Gated frequency meter. Counts rising edges of sig_in over a    |
// |             window of CLK_REF/GATE_HZ enabled cycles, then scales the      |
// |             count by GATE_HZ to report Hz. Windows repeat back-to-back     |
// |             while run is high, with one dead (latch) cycle between them.   |
// | Params    : CLK_REF  reference clock frequency in Hz                       |
// |             GATE_HZ  gate rate in Hz                                       |
// |             W_EDGE   edge counter width                                    |
// | Ports     : clk      clock                                                 |
// |             reset_l  synchronous active-high reset                         |
// |             bus      freq_meter_if.slave (clk_en, run, sig_in in;          |
// |                      relax_freq, work, ovf, no_sig out)                    |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int unsigned CLK_REF = CLK_REF_DEF,
   parameter int unsigned GATE_HZ = GATE_HZ_DEF,
   parameter int unsigned W_EDGE  = 20
) (
   input  wire logic    clk,
   input  wire logic    reset_l,
   freq_meter_if.slave  bus
);

   localparam int unsigned GATE_CYC = gate_cycles(CLK_REF, GATE_HZ);
   localparam int unsigned GATE_W   = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
   localparam int unsigned PROD_W   = FREQ_W + W_EDGE;

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYC - 1);
   localparam logic [W_EDGE-1:0] EDGE_MAX  = '1;
   localparam logic [PROD_W-1:0] HZ_EXT    = PROD_W'(GATE_HZ);

   state_t              state;
   state_t              state_nxt;

   logic                cnt_clear;
   logic                cnt_step;
   logic                latch_now;
   logic                abort_now;

   logic [GATE_W-1:0]   gate_cnt;
   logic [W_EDGE-1:0]   edge_cnt;
   logic                sat;
   logic                edge_det;

   logic [PROD_W-1:0]   product;
   logic                prod_sat;

   logic [FREQ_W-1:0]   freq_reg;
   logic                work_reg;
   logic                ovf_reg;
   logic                no_sig_reg;

   // ---------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------
   edge_sync u_edge_sync (
      .clk      (clk),
      .reset_l  (reset_l),
      .clk_en   (bus.clk_en),
      .sig_in   (bus.sig_in),
      .edge_det (edge_det)
   );

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset_l) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state and per-cycle controls. Nothing moves on a disabled
   // cycle, so every control defaults to inactive.
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_clear = 1'b0;
      cnt_step  = 1'b0;
      latch_now = 1'b0;
      abort_now = 1'b0;

      if (bus.clk_en) begin
         unique case (state)
            IDLE: begin
               cnt_clear = 1'b1;
               if (bus.run) begin
                  state_nxt = GATE;
               end
            end

            GATE: begin
               if (!bus.run) begin
                  // Abort wins even on the final gate cycle: the partial
                  // window is discarded and the last result is kept.
                  state_nxt = IDLE;
                  cnt_clear = 1'b1;
                  abort_now = 1'b1;
               end else begin
                  cnt_step = 1'b1;
                  if (gate_cnt == GATE_LAST) begin
                     state_nxt = LATCH;
                  end
               end
            end

            LATCH: begin
               // The dead cycle: result is published and counters restart,
               // so an edge arriving now belongs to neither window.
               latch_now = 1'b1;
               cnt_clear = 1'b1;
               state_nxt = bus.run ? GATE : IDLE;
            end

            default: begin
               state_nxt = IDLE;
               cnt_clear = 1'b1;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Gate and edge counters
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset_l) begin
         gate_cnt <= '0;
         edge_cnt <= '0;
         sat      <= 1'b0;
      end else if (cnt_clear) begin
         gate_cnt <= '0;
         edge_cnt <= '0;
         sat      <= 1'b0;
      end else if (cnt_step) begin
         gate_cnt <= gate_cnt + 1'b1;
         if (edge_det) begin
            // Hold at full scale and remember that edges were lost.
            if (edge_cnt == EDGE_MAX) begin
               sat <= 1'b1;
            end else begin
               edge_cnt <= edge_cnt + 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Scaling: count * GATE_HZ in a wide intermediate, clamped to 32 bits.
   // ---------------------------------------------------------------------
   assign product  = PROD_W'(edge_cnt) * HZ_EXT;
   assign prod_sat = |product[PROD_W-1:FREQ_W];

   // ---------------------------------------------------------------------
   // Result registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset_l) begin
         freq_reg   <= '0;
         work_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
         no_sig_reg <= 1'b0;
      end else if (latch_now) begin
         freq_reg   <= prod_sat ? {FREQ_W{1'b1}} : product[FREQ_W-1:0];
         ovf_reg    <= sat | prod_sat;
         no_sig_reg <= (edge_cnt == '0);
         work_reg   <= 1'b1;
      end else if (abort_now) begin
         // Keep the stale reading visible but flag it as interrupted.
         work_reg   <= 1'b0;
      end
   end

   assign bus.relax_freq = freq_reg;
   assign bus.work       = work_reg;
   assign bus.ovf        = ovf_reg;
   assign bus.no_sig     = no_sig_reg;

endmodule : freq_meter
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_freq_meter                                                  |
// | Purpose   : Self-checking bench for freq_meter. Each episode starts with   |
// |             a reset and plays a precomputed stimulus table; a reference    |
// |             model derives expected outputs from the sampled-signal         |
// |             sequence and the window rules, queued by due clock edge; a     |
// |             monitor compares when each entry falls due.                    |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_freq_meter;

   localparam int TB_CLK_REF = 200_000;
   localparam int TB_GATE_HZ = 1_000;
   localparam int TB_W_EDGE  = 6;
   localparam int GATE_CYC   = TB_CLK_REF / TB_GATE_HZ;
   localparam int EMAX       = (1 << TB_W_EDGE) - 1;

   typedef struct packed {
      int          due;
      logic [31:0] relax;
      logic        work;
      logic        ovf;
      logic        no_sig;
      logic [1:0]  kind;
   } exp_t;

   logic clk;
   logic reset_l;
   int   edge_no = 0;
   int   n_cmp   = 0;
   int   n_bad   = 0;

   exp_t sb[$];

   bit   ep_en[];
   bit   ep_sg[];
   bit   ep_rn[];

   freq_meter_if bus ();

   freq_meter #(
      .CLK_REF (TB_CLK_REF),
      .GATE_HZ (TB_GATE_HZ),
      .W_EDGE  (TB_W_EDGE)
   ) dut (
      .clk     (clk),
      .reset_l (reset_l),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_no <= edge_no + 1;

   function automatic string kind_name(input logic [1:0] k);
      case (k)
         2'd0:    return "reset";
         2'd1:    return "window";
         default: return "abort";
      endcase
   endfunction

   task automatic push_exp(input int due, input logic [31:0] relax, input logic work,
                           input logic ovf, input logic no_sig, input logic [1:0] kind);
      exp_t e;
      e.due = due; e.relax = relax; e.work = work;
      e.ovf = ovf; e.no_sig = no_sig; e.kind = kind;
      sb.push_back(e);
   endtask

   // Reference model: walk the enabled cycles of the table. An edge counted
   // on enabled cycle k is a 0->1 step between samples k-3 and k-2.
   task automatic predict(input int base);
      bit          hist[$];
      int          phase = 0;     // 0 waiting for run, 1 in window, 2 publish
      int          pos   = 0;
      int          cnt   = 0;
      bit          a, b, e;
      int          k;
      longint      prod;
      logic [31:0] m_relax = 32'd0;
      bit          m_work = 1'b0, m_ovf = 1'b0, m_ns = 1'b0;

      push_exp(base, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0);
      for (int i = 1; i < ep_en.size(); i++) begin
         if (!ep_en[i]) continue;
         k = hist.size();
         a = (k >= 2) ? hist[k-2] : 1'b0;
         b = (k >= 3) ? hist[k-3] : 1'b0;
         e = a && !b;
         hist.push_back(ep_sg[i]);
         case (phase)
            0: begin
               if (ep_rn[i]) begin
                  phase = 1; pos = 0; cnt = 0;
               end
            end
            1: begin
               if (!ep_rn[i]) begin
                  phase = 0; m_work = 1'b0;
                  push_exp(base + i, m_relax, m_work, m_ovf, m_ns, 2'd2);
               end else begin
                  cnt += int'(e);
                  pos++;
                  if (pos == GATE_CYC) phase = 2;
               end
            end
            default: begin
               prod    = longint'((cnt > EMAX) ? EMAX : cnt) * TB_GATE_HZ;
               m_ovf   = (cnt > EMAX) || (prod > 64'h0000_0000_FFFF_FFFF);
               m_relax = (prod > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : prod[31:0];
               m_ns    = (cnt == 0);
               m_work  = 1'b1;
               push_exp(base + i, m_relax, m_work, m_ovf, m_ns, 2'd1);
               phase = ep_rn[i] ? 1 : 0;
               pos = 0; cnt = 0;
            end
         endcase
      end
   endtask

   // kind: 0 sq/4, 1 silent, 2 sq/2 (saturating), 3 abort+restart,
   //       4 clk_en 50% with sq/8, 5 random
   task automatic build(input int kind);
      int len, per, ph, en_mode, sg_mode, st, d_at, d_len, dens;
      bit s;
      len = 480; per = 4; ph = 0; en_mode = 0; sg_mode = 0;
      st = 1; d_at = -1; d_len = 0; dens = 100;
      case (kind)
         0: begin per = 4; end
         1: begin sg_mode = 2; end
         2: begin per = 2; end
         3: begin per = 6; len = 560; d_at = 300; d_len = 5; end
         4: begin per = 8; en_mode = 1; len = 900; end
         default: begin
            len     = $urandom_range(300, 1200);
            per     = $urandom_range(2, 40);
            ph      = $urandom_range(0, 39);
            en_mode = $urandom_range(0, 2);
            dens    = $urandom_range(25, 100);
            sg_mode = $urandom_range(0, 3);
            st      = $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 1) begin
               d_at  = $urandom_range(1, len - 1);
               d_len = $urandom_range(1, 30);
            end
         end
      endcase
      ep_en = new[len]; ep_sg = new[len]; ep_rn = new[len];
      s = 1'b0;
      for (int i = 0; i < len; i++) begin
         case (en_mode)
            0:       ep_en[i] = 1'b1;
            1:       ep_en[i] = (i % 2) == 1;
            default: ep_en[i] = $urandom_range(1, 100) <= dens;
         endcase
         case (sg_mode)
            2:       ep_sg[i] = 1'b0;
            3: begin
               if ($urandom_range(0, 3) == 0) s = ~s;
               ep_sg[i] = s;
            end
            default: ep_sg[i] = ((i + ph) % per) < (per / 2);
         endcase
         ep_rn[i] = (i >= st) && !((i >= d_at) && (i < d_at + d_len));
      end
      ep_rn[0] = $urandom_range(0, 1) == 1;
      ep_en[0] = $urandom_range(0, 1) == 1;
   endtask

   task automatic drive_episode();
      for (int i = 0; i < ep_en.size(); i++) begin
         reset_l    = (i == 0);
         bus.clk_en = ep_en[i];
         bus.run    = ep_rn[i];
         bus.sig_in = ep_sg[i];
         @(negedge clk);
      end
   endtask

   // Monitor: compare every expectation on the negedge after its due edge.
   always @(negedge clk) begin
      exp_t x;
      while (sb.size() > 0 && sb[0].due <= edge_no) begin
         x = sb.pop_front();
         n_cmp++;
         if (x.due != edge_no) begin
            n_bad++;
            $display("FAIL %s: check due at edge %0d missed (now %0d)",
                     kind_name(x.kind), x.due, edge_no);
         end else if ({bus.relax_freq, bus.work, bus.ovf, bus.no_sig} !==
                      {x.relax, x.work, x.ovf, x.no_sig}) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got relax=%0d work=%b ovf=%b no_sig=%b, expected relax=%0d work=%b ovf=%b no_sig=%b",
                     kind_name(x.kind), edge_no, bus.relax_freq, bus.work, bus.ovf,
                     bus.no_sig, x.relax, x.work, x.ovf, x.no_sig);
         end
      end
   end

   initial begin
      reset_l    = 1'b1;
      bus.clk_en = 1'b0;
      bus.run    = 1'b0;
      bus.sig_in = 1'b0;
      @(negedge clk);
      for (int ep = 0; ep < 21; ep++) begin
         build((ep < 5) ? ep : 5);
         predict(edge_no + 1);
         drive_episode();
      end
      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations never reached, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_freq_meter
`default_nettype wire
